// File: rtl/pipeline_fetch_ctrl.sv
// Fetch-side controller: owns the fetch PC and the F/D/X instruction, PC and valid
// registers, steering them from the next-PC select code and the D/X kill requests.
module pipeline_fetch_ctrl #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013,
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       PCSel_F_out,
    input  logic             killD_req_next,
    input  logic             killX_req_next,
    input  logic [XLEN-1:0]  immF,
    input  logic [XLEN-1:0]  immD,
    input  logic [XLEN-1:0]  ALUoutX,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCX,
    output logic [31:0]      instF,
    output logic [31:0]      instD,
    output logic [31:0]      instX,
    output logic             validF,
    output logic             validD,
    output logic             validX,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             illegal_sel
);

    typedef enum logic [1:0] {BOOT, FILL, RUN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] next_pc;
    logic            sel_illegal;
    logic            active;
    logic            advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        active    = 1'b1;
        case (state)
            BOOT:    begin state_nxt = FILL; active = 1'b0; end
            FILL:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: begin state_nxt = BOOT; active = 1'b0; end
        endcase
    end

    // Illegal codes fall back to sequential fetch; only the sticky flag records them.
    always_comb begin
        next_pc     = PCF + XLEN'(4);
        sel_illegal = 1'b0;
        case (PCSel_F_out)
            3'd0:    next_pc = PCF + XLEN'(4);
            3'd1:    next_pc = PCF + immF;
            3'd2:    next_pc = {ALUoutX[XLEN-1:1], 1'b0};
            3'd3:    next_pc = PCD + immD;
            3'd4:    next_pc = PCD + XLEN'(4);
            default: sel_illegal = 1'b1;
        endcase
    end

    // A D-kill is a redirect and must win over a stall, so it forces the pipe to move.
    assign advance   = ~stall | killD_req_next;
    assign validF    = active;
    assign instF     = imem_rdata;
    assign imem_addr = PCF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF          <= RESET_PC;
            PCD          <= '0;
            PCX          <= '0;
            instD        <= NOP_INST;
            instX        <= NOP_INST;
            validD       <= 1'b0;
            validX       <= 1'b0;
            redirect_cnt <= '0;
            illegal_sel  <= 1'b0;
        end else if (active) begin
            if (advance) begin
                PCF    <= next_pc;
                PCD    <= PCF;
                instD  <= killD_req_next ? NOP_INST : instF;
                validD <= validF & ~killD_req_next;
                PCX    <= PCD;
                instX  <= killX_req_next ? NOP_INST : instD;
                validX <= validD & ~killX_req_next;
            end else begin
                validX <= 1'b0;
                instX  <= NOP_INST;
            end
            if (killD_req_next && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + 1'b1;
            if (validF && sel_illegal)
                illegal_sel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Directed bench for pipeline_fetch_ctrl: reset/fill, branches, kills, stalls,
// counter saturation (narrow counter) and the sticky illegal-select flag.
module tb_pipeline_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TAG  = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        killD = 1'b0, killX = 1'b0;
    logic [31:0] immF = '0, immD = '0, aluX = '0;
    logic [31:0] imem_rdata, imem_addr, PCF, PCD, PCX, instF, instD, instX;
    logic        validF, validD, validX, illegal_sel;
    logic [1:0]  redirect_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = TAG ^ imem_addr;

    pipeline_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(NOP), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .PCSel_F_out(sel),
        .killD_req_next(killD), .killX_req_next(killX),
        .immF(immF), .immD(immD), .ALUoutX(aluX), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .PCF(PCF), .PCD(PCD), .PCX(PCX),
        .instF(instF), .instD(instD), .instX(instX),
        .validF(validF), .validD(validD), .validX(validX),
        .redirect_cnt(redirect_cnt), .illegal_sel(illegal_sel)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #12;
        checks++; if (PCF !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h/%h exp=0", PCF, imem_addr); end
        checks++; if ({validF, validD, validX} !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b exp=000", {validF, validD, validX}); end
        checks++; if (instD !== NOP || instX !== NOP) begin errors++; $display("FAIL reset_inst got=%h/%h exp=%h", instD, instX, NOP); end
        checks++; if (redirect_cnt !== 2'd0 || illegal_sel !== 1'b0) begin errors++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", redirect_cnt, illegal_sel); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (PCF !== 32'h0 || validF !== 1'b0) begin errors++; $display("FAIL boot got pc=%h vf=%b exp=0/0", PCF, validF); end
        step();
        checks++; if (PCF !== 32'h0 || validF !== 1'b1 || validD !== 1'b0) begin errors++; $display("FAIL fill got pc=%h vf=%b vd=%b exp=0/1/0", PCF, validF, validD); end
        step();
        checks++; if (PCF !== 32'h4 || validD !== 1'b1 || validX !== 1'b0 || PCD !== 32'h0 || instD !== TAG) begin errors++; $display("FAIL run1 got pc=%h vd=%b vx=%b pcd=%h id=%h exp=4/1/0/0/%h", PCF, validD, validX, PCD, instD, TAG); end
        step();
        checks++; if (PCF !== 32'h8 || validX !== 1'b1 || PCX !== 32'h0 || instX !== TAG || PCD !== 32'h4) begin errors++; $display("FAIL run2 got pc=%h vx=%b pcx=%h ix=%h pcd=%h exp=8/1/0/%h/4", PCF, validX, PCX, instX, PCD, TAG); end
        checks++; if (instF !== (TAG ^ 32'h8)) begin errors++; $display("FAIL instF got=%h exp=%h", instF, TAG ^ 32'h8); end
    endtask

    task automatic test_jal();
        step(); step();
        checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL jal_pre got=%h exp=10", PCF); end
        sel = 3'd1; immF = 32'h40;
        step();
        sel = 3'd0;
        checks++; if (PCF !== 32'h50 || validD !== 1'b1 || validX !== 1'b1 || PCD !== 32'h10) begin errors++; $display("FAIL jal got pc=%h vd=%b vx=%b pcd=%h exp=50/1/1/10", PCF, validD, validX, PCD); end
    endtask

    task automatic test_mispredict();
        sel = 3'd3; killD = 1'b1; immD = 32'h100;
        step();
        sel = 3'd0; killD = 1'b0;
        checks++; if (PCF !== 32'h110 || validD !== 1'b0 || instD !== NOP || PCD !== 32'h50) begin errors++; $display("FAIL mispredict got pc=%h vd=%b id=%h pcd=%h exp=110/0/%h/50", PCF, validD, instD, PCD, NOP); end
        checks++; if (redirect_cnt !== 2'd1 || validX !== 1'b1) begin errors++; $display("FAIL mispredict_cnt got cnt=%0d vx=%b exp=1/1", redirect_cnt, validX); end
    endtask

    task automatic test_jalr();
        step();
        checks++; if (PCF !== 32'h114 || validD !== 1'b1 || validX !== 1'b0) begin errors++; $display("FAIL jalr_pre got pc=%h vd=%b vx=%b exp=114/1/0", PCF, validD, validX); end
        sel = 3'd2; aluX = 32'h203; killD = 1'b1; killX = 1'b1;
        step();
        sel = 3'd0; killD = 1'b0; killX = 1'b0;
        checks++; if (PCF !== 32'h202 || validD !== 1'b0 || validX !== 1'b0 || instX !== NOP) begin errors++; $display("FAIL jalr got pc=%h vd=%b vx=%b ix=%h exp=202/0/0/%h", PCF, validD, validX, instX, NOP); end
        checks++; if (redirect_cnt !== 2'd2) begin errors++; $display("FAIL jalr_cnt got=%0d exp=2", redirect_cnt); end
    endtask

    task automatic test_stall();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (PCF !== 32'h206 || PCD !== 32'h202 || instD !== (TAG ^ 32'h202) || validD !== 1'b1 || validX !== 1'b0 || instX !== NOP) begin
                errors++; $display("FAIL stall%0d got pc=%h pcd=%h id=%h vd=%b vx=%b ix=%h exp=206/202/%h/1/0/%h", i, PCF, PCD, instD, validD, validX, instX, TAG ^ 32'h202, NOP);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (PCF !== 32'h20A || PCD !== 32'h206 || validX !== 1'b1 || PCX !== 32'h202 || instX !== (TAG ^ 32'h202)) begin errors++; $display("FAIL stall_release got pc=%h pcd=%h vx=%b pcx=%h ix=%h exp=20a/206/1/202/%h", PCF, PCD, validX, PCX, instX, TAG ^ 32'h202); end
    endtask

    task automatic test_stall_kill();
        stall = 1'b1; killD = 1'b1; sel = 3'd3; immD = 32'h10;
        step();
        stall = 1'b0; killD = 1'b0; sel = 3'd0;
        checks++; if (PCF !== 32'h216 || validD !== 1'b0 || PCD !== 32'h20A || validX !== 1'b1 || PCX !== 32'h206) begin errors++; $display("FAIL stall_kill got pc=%h vd=%b pcd=%h vx=%b pcx=%h exp=216/0/20a/1/206", PCF, validD, PCD, validX, PCX); end
        checks++; if (redirect_cnt !== 2'd3) begin errors++; $display("FAIL stall_kill_cnt got=%0d exp=3", redirect_cnt); end
        killD = 1'b1;
        step();
        killD = 1'b0;
        checks++; if (redirect_cnt !== 2'd3 || PCF !== 32'h21A) begin errors++; $display("FAIL cnt_sat got cnt=%0d pc=%h exp=3/21a", redirect_cnt, PCF); end
    endtask

    task automatic test_illegal();
        checks++; if (illegal_sel !== 1'b0) begin errors++; $display("FAIL illegal_pre got=%b exp=0", illegal_sel); end
        sel = 3'd6;
        step();
        sel = 3'd0;
        checks++; if (PCF !== 32'h21E || illegal_sel !== 1'b1) begin errors++; $display("FAIL illegal got pc=%h flag=%b exp=21e/1", PCF, illegal_sel); end
        step();
        checks++; if (PCF !== 32'h222 || illegal_sel !== 1'b1) begin errors++; $display("FAIL illegal_sticky got pc=%h flag=%b exp=222/1", PCF, illegal_sel); end
        #2 rst_n = 1'b0; #1;
        checks++; if (illegal_sel !== 1'b0 || PCF !== 32'h0 || validF !== 1'b0 || redirect_cnt !== 2'd0) begin errors++; $display("FAIL async_reset got flag=%b pc=%h vf=%b cnt=%0d exp=0/0/0/0", illegal_sel, PCF, validF, redirect_cnt); end
        @(negedge clk); rst_n = 1'b1; killD = 1'b1;
        step();
        killD = 1'b0;
        checks++; if (redirect_cnt !== 2'd0 || PCF !== 32'h0 || validF !== 1'b1) begin errors++; $display("FAIL boot_kill got cnt=%0d pc=%h vf=%b exp=0/0/1", redirect_cnt, PCF, validF); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_mispredict();
        test_jalr();
        test_stall();
        test_stall_kill();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
